// File: rtl/collatz_sweep_if.sv
// -----------------------------------------------------------------------------
// collatz_sweep_if
// Handshake/readback bundle for collatz_sweep.
//   go    : start-sweep request, sampled every cycle (master -> slave)
//   start : sweep base value when go is high, readback address otherwise
//   done  : one-cycle pulse when a sweep has completed (slave -> master)
//   count : registered RAM readback word (slave -> master)
// -----------------------------------------------------------------------------
interface collatz_sweep_if #(
    parameter int COUNT_BITS = 16
);
    logic                  go;
    logic [31:0]           start;
    logic                  done;
    logic [COUNT_BITS-1:0] count;

    modport master (
        output go,
        output start,
        input  done,
        input  count
    );

    modport slave (
        input  go,
        input  start,
        output done,
        output count
    );
endinterface

// File: rtl/collatz_sweep.sv
// -----------------------------------------------------------------------------
// collatz_sweep
// Sweeps RAM_WORDS consecutive start values (base, base+1, ...) through the
// Collatz iteration and stores, per value, the number of terms in its sequence
// (start and final 1 included, saturating at 2**COUNT_BITS-1) into an internal
// RAM. The RAM is read back one word per cycle through the same bus.
//
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : collatz_sweep_if.slave (go, start, done, count)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for go; latches base and clears the entry index
// LOAD   | n <= base+i, c <= 1 (value 0 or 1 needs no iteration)
// ITER   | one Collatz step per cycle until n reaches 1
// WRITE  | mem[i] <= c, then next entry or FINISH
// FINISH | raises done for one cycle, back to IDLE
// -----------------------------------------------------------------------------
module collatz_sweep #(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8,
    parameter int COUNT_BITS    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    collatz_sweep_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        WRITE,
        FINISH
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);
    localparam logic [COUNT_BITS-1:0]    C_MAX    = '1;

    state_t                   state;
    logic [31:0]              base;
    logic [31:0]              n;
    logic [RAM_ADDR_BITS-1:0] i;
    logic [COUNT_BITS-1:0]    c;
    logic                     done_r;
    logic [COUNT_BITS-1:0]    count_r;

    logic [COUNT_BITS-1:0]    mem [RAM_WORDS];

    logic [31:0]              load_val;
    logic [31:0]              n_next;
    logic [COUNT_BITS-1:0]    c_inc;

    assign load_val = base + 32'(i);
    // 3n+1 as shift-and-add; wraps modulo 2**32
    assign n_next   = n[0] ? ((n << 1) + n + 32'd1) : (n >> 1);
    assign c_inc    = (c == C_MAX) ? c : c + COUNT_BITS'(1);

    // Leaving ITER on the step that produces 1 (instead of spending another
    // cycle looking at n==1) keeps the per-entry cost at count+1 cycles.
    // A start value that wraps to 0 under 3n+1 never terminates; the sweep
    // simply runs until reset in that case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_r <= 1'b0;
            base   <= '0;
            n      <= '0;
            i      <= '0;
            c      <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        base  <= bus.start;
                        i     <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    n <= load_val;
                    if (load_val == 32'd0) begin
                        c     <= '0;
                        state <= WRITE;
                    end else begin
                        c     <= COUNT_BITS'(1);
                        state <= (load_val == 32'd1) ? WRITE : ITER;
                    end
                end
                ITER: begin
                    if (n == 32'd1) begin
                        state <= WRITE;
                    end else begin
                        n <= n_next;
                        c <= c_inc;
                        if (n_next == 32'd1) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (i == LAST_IDX) begin
                        state <= FINISH;
                    end else begin
                        i     <= i + RAM_ADDR_BITS'(1);
                        state <= LOAD;
                    end
                end
                FINISH: begin
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM contents survive reset; a same-address read in the write cycle
    // returns the previous word.
    always_ff @(posedge clk) begin
        if (state == WRITE) begin
            mem[i] <= c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            count_r <= mem[bus.start[RAM_ADDR_BITS-1:0]];
        end
    end

    assign bus.done  = done_r;
    assign bus.count = count_r;

endmodule

// File: tb/tb_collatz_sweep.sv
// -----------------------------------------------------------------------------
// tb_collatz_sweep
// Three instances: default geometry (256 words), a 2-word RAM for exact
// latency and read-during-write behaviour, and a 2-word RAM with 4-bit counts
// for saturation. Readbacks go through a scoreboard queue; sweeps are timed
// against a reference Collatz model.
// -----------------------------------------------------------------------------
module tb_collatz_sweep;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    collatz_sweep_if #(.COUNT_BITS(16)) m_if ();
    collatz_sweep_if #(.COUNT_BITS(16)) s_if ();
    collatz_sweep_if #(.COUNT_BITS(4))  t_if ();

    collatz_sweep #(.RAM_WORDS(256), .RAM_ADDR_BITS(8), .COUNT_BITS(16)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    collatz_sweep #(.RAM_WORDS(2), .RAM_ADDR_BITS(1), .COUNT_BITS(16)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    collatz_sweep #(.RAM_WORDS(2), .RAM_ADDR_BITS(1), .COUNT_BITS(4)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (t_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          phase;
        int          sel;
        int unsigned addr;
        int unsigned exp;
    } vec_t;

    typedef struct {
        string       name;
        int          sel;
        int unsigned exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];

    // ---------------- reference model ----------------
    function automatic int unsigned ref_terms(input int unsigned v0);
        int unsigned v;
        int unsigned t;
        v = v0;
        if (v == 0) return 0;
        t = 1;
        while (v != 1 && t < 100000) begin
            if (v[0]) v = v * 3 + 1;
            else      v = v >> 1;
            t++;
        end
        return t;
    endfunction

    function automatic int unsigned ref_count(input int unsigned v, input int bits);
        int unsigned t;
        int unsigned mx;
        t  = ref_terms(v);
        mx = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 1);
        return (t > mx) ? mx : t;
    endfunction

    function automatic int entry_lat(input int unsigned v);
        return (v == 0) ? 2 : int'(ref_terms(v)) + 1;
    endfunction

    // edges from the go-sampling edge to the edge that raises done
    function automatic int sweep_lat(input int unsigned base, input int words);
        int total;
        total = 0;
        for (int k = 0; k < words; k++) total += entry_lat(base + k);
        return total + 1;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic g, input logic [31:0] s);
        case (sel)
            0:       begin m_if.go = g; m_if.start = s; end
            1:       begin s_if.go = g; s_if.start = s; end
            default: begin t_if.go = g; t_if.start = s; end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return m_if.done;
            1:       return s_if.done;
            default: return t_if.done;
        endcase
    endfunction

    function automatic int unsigned get_count(input int sel);
        case (sel)
            0:       return 32'(m_if.count);
            1:       return 32'(s_if.count);
            default: return 32'(t_if.count);
        endcase
    endfunction

    task automatic readback(input int sel, input int unsigned addr, input int unsigned exp,
                            input string nm);
        sb_t e;
        sb_t got;
        drive(sel, 1'b0, addr);
        e.name = nm;
        e.sel  = sel;
        e.exp  = exp;
        sbq.push_back(e);
        @(posedge clk); #1;
        got = sbq.pop_front();
        check(got.name, get_count(got.sel), got.exp);
    endtask

    task automatic apply_table(input int phase);
        foreach (vecs[k]) begin
            if (vecs[k].phase == phase)
                readback(vecs[k].sel, vecs[k].addr, vecs[k].exp,
                         $sformatf("rb_p%0d_a%0d", phase, vecs[k].addr));
        end
    endtask

    task automatic model_reads(input int phase, input int unsigned base);
        int unsigned a;
        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(0, 255);
            readback(0, a, ref_count(base + a, 16), $sformatf("model_p%0d_a%0d", phase, a));
        end
    endtask

    // caller is at posedge+1; go is presented for one cycle
    task automatic run_sweep(input int sel, input int unsigned base, input int exp_lat,
                             input int inject_at, input string nm);
        int first;
        int pulses;
        first  = -1;
        pulses = 0;
        drive(sel, 1'b1, base);
        @(posedge clk); #1;
        drive(sel, 1'b0, base);
        for (int cyc = 1; cyc <= 30000 && first < 0; cyc++) begin
            if (inject_at > 0 && cyc == inject_at)     drive(sel, 1'b1, 32'd100);
            if (inject_at > 0 && cyc == inject_at + 1) drive(sel, 1'b0, 32'd100);
            @(posedge clk); #1;
            if (get_done(sel)) begin
                pulses++;
                first = cyc;
            end
        end
        if (first < 0) begin
            check({nm, "_timeout"}, 0, 1);
        end else begin
            check({nm, "_latency"}, first, exp_lat);
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                if (get_done(sel)) pulses++;
            end
            check({nm, "_pulses"}, pulses, 1);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int pulses;
        int wl;
        bit seen;

        // phase 0: main, base 1
        vecs.push_back('{0, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 2});
        vecs.push_back('{0, 0, 2, 8});
        vecs.push_back('{0, 0, 6, 17});
        vecs.push_back('{0, 0, 255, 9});
        // phase 1: main, base 0
        vecs.push_back('{1, 0, 0, 0});
        vecs.push_back('{1, 0, 1, 1});
        vecs.push_back('{1, 0, 2, 2});
        vecs.push_back('{1, 0, 27, 112});
        // phase 2: main, base 5 with a stray go at 100
        vecs.push_back('{2, 0, 0, 6});
        vecs.push_back('{2, 0, 2, 17});
        // phase 3: main, base 1 after reset mid-sweep
        vecs.push_back('{3, 0, 0, 1});
        vecs.push_back('{3, 0, 6, 17});
        vecs.push_back('{3, 0, 200, ref_count(201, 16)});
        // phase 4: small, base 1
        vecs.push_back('{4, 1, 0, 1});
        vecs.push_back('{4, 1, 1, 2});
        // phase 5: 4-bit counts, base 27
        vecs.push_back('{5, 2, 0, 15});
        vecs.push_back('{5, 2, 1, 15});

        rst_n = 1'b0;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        drive(2, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", 32'(m_if.done), 0);
        check("reset_count", get_count(0), 0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (m_if.done || s_if.done || t_if.done) pulses++;
        end
        check("no_done_after_reset", pulses, 0);

        run_sweep(0, 1, sweep_lat(1, 256), 0, "sweep_b1");
        apply_table(0);
        model_reads(0, 1);

        run_sweep(0, 0, sweep_lat(0, 256), 0, "sweep_b0");
        apply_table(1);
        model_reads(1, 0);

        run_sweep(0, 5, sweep_lat(5, 256), 30, "sweep_b5_go");
        apply_table(2);
        model_reads(2, 5);

        // abandon a sweep partway through entry 7's iteration
        drive(0, 1'b1, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (m_if.done) pulses++;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midreset_done", 32'(m_if.done), 0);
        check("midreset_count", get_count(0), 0);
        repeat (3) begin
            @(posedge clk); #1;
            if (m_if.done) pulses++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (m_if.done) pulses++;
        end
        check("midreset_no_done", pulses, 0);

        run_sweep(0, 1, sweep_lat(1, 256), 0, "sweep_after_reset");
        apply_table(3);
        model_reads(3, 1);

        // 2-word RAM: (1+1) + (2+1) + 1 edges from the go-sampling edge
        run_sweep(1, 1, 6, 0, "small_b1");
        apply_table(4);

        // read mem[0] while entry 0 of a base-3 sweep is written into it
        drive(1, 1'b1, 3);
        @(posedge clk); #1;
        drive(1, 1'b0, 0);
        wl = entry_lat(3);
        for (int k = 1; k <= wl + 1; k++) begin
            @(posedge clk); #1;
            if (k == wl)     check("rdw_old", get_count(1), 1);
            if (k == wl + 1) check("rdw_new", get_count(1), 8);
        end
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #1;
            if (s_if.done) seen = 1'b1;
        end
        check("rdw_sweep_done", 32'(seen), 1);
        readback(1, 1, 3, "small_b3_a1");

        run_sweep(2, 27, sweep_lat(27, 2), 0, "sat_b27");
        apply_table(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collatz_sweep.md
COLLATZ_SWEEP -- requirements
Module: collatz_sweep

Interface
- REQ-001 SHALL have parameter RAM_WORDS, default 256: number of consecutive start values swept and RAM depth.
- REQ-002 SHALL have parameter RAM_ADDR_BITS, default 8: RAM address width; RAM_WORDS = 2**RAM_ADDR_BITS.
- REQ-003 SHALL have parameter COUNT_BITS, default 16: width of each stored iteration count.
- REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
- REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 SHALL have port go, input, 1 bit: start-sweep request, sampled per cycle.
- REQ-007 SHALL have port start, input, 32 bits: sweep base value when go is sampled; readback address (low RAM_ADDR_BITS bits) otherwise.
- REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse on sweep completion.
- REQ-009 SHALL have port count, output, COUNT_BITS: registered RAM readback.

Function
- REQ-010 SHALL implement states IDLE, LOAD, ITER, WRITE, FINISH.
- REQ-011 In IDLE, go=1 SHALL latch base<=start and index i<=0, then move to LOAD next cycle.
- REQ-012 go in any state other than IDLE SHALL be ignored; it SHALL NOT restart or corrupt the sweep.
- REQ-013 LOAD SHALL set n<=base+i (32-bit, modulo 2^32) and c<=1, then go to ITER; base+i=0 SHALL go directly to WRITE with c=0.
- REQ-014 ITER, one step per cycle: n==1 -> WRITE; n even -> n<=n>>1, c<=c+1; n odd -> n<=3n+1 (modulo 2^32), c<=c+1.
- REQ-015 c SHALL saturate at 2^COUNT_BITS-1 and never wrap.
- REQ-016 Stored value SHALL equal the number of terms in the sequence, counting the start and the final 1: count(1)=1, count(2)=2, count(3)=8, count(7)=17, count(0)=0.
- REQ-017 WRITE SHALL store c at mem[i] in one cycle; if i==RAM_WORDS-1, go to FINISH, else i<=i+1 and go to LOAD.
- REQ-018 Per-entry latency SHALL be count(n)+1 cycles (LOAD + count(n)-1 ITER + WRITE); for n=0 it SHALL be 2 cycles.
- REQ-019 FINISH SHALL assert done=1 for exactly one cycle and return to IDLE.
- REQ-020 Every cycle, count SHALL load mem[start[RAM_ADDR_BITS-1:0]], giving one cycle of read latency.
- REQ-021 On a read and write to the same address in the same cycle, count SHALL return the old data.
- REQ-022 start changes after go SHALL NOT affect the running sweep; only the latched base SHALL be used.
- REQ-023 A new sweep SHALL overwrite all RAM_WORDS entries.

Reset
- REQ-024 rst_n=0 SHALL immediately force state=IDLE, done=0, count=0, i=0, n=0, c=0, base=0.
- REQ-025 RAM contents SHALL NOT be reset; they are undefined until the first completed sweep.
- REQ-026 Reset mid-sweep SHALL abandon the sweep with no done pulse; the next go SHALL start cleanly.
- REQ-027 Deassertion of rst_n SHALL take effect at the first following clk edge, with no spurious done.

Verification
- REQ-028 Sweep 1: go with start=1 -> exactly one done pulse; readback start=0,1,2,6 -> count=1,2,8,17 one cycle later.
- REQ-029 Latency: RAM_WORDS=2, start=1 -> done asserted exactly (1+1)+(2+1)+1 cycles after go plus the IDLE->LOAD cycle; check against a cycle-exact model.
- REQ-030 Zero entry: start=0 -> mem[0]=0, mem[1]=1, mem[27]=112 (start value 27).
- REQ-031 Ignored go: pulse go and change start to 100 mid-sweep -> results still those of the original base; single done pulse.
- REQ-032 Reset mid-sweep: assert rst_n=0 during ITER -> done=0 and count=0 immediately, no done pulse; a new go with start=1 completes correctly.
- REQ-033 Saturation: COUNT_BITS=4, start=27 -> mem[0]=15.
